// File: rtl/neuron_pkg.sv
// Shared types and default widths for the neuron accumulate/activate stage.
// Optional build macro: NEURON_RELU_EN (ReLU activation in neuron_sat_act).
package neuron_pkg;

  localparam int NEURON_IN_W  = 4;
  localparam int NEURON_OUT_W = 6;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } neuron_acc_state_t;

  // sat_clip(acc) -> signed OUT_W value clamped to the
  // OUT_W range; the implementation lives in neuron_sat_act.

endpackage

// File: rtl/neuron_accum_act_if.sv
// Valid/ready term input and result output bundle for neuron_accum_act.
// The NEURON_RELU_EN macro has no effect on this bundle.
interface neuron_accum_act_if
  import neuron_pkg::*;
#(
  parameter int IN_W  = NEURON_IN_W,
  parameter int OUT_W = NEURON_OUT_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/neuron_accum_act_sat_act.sv
// neuron_sat_act: clamp a signed sum to OUT_W bits, then activate.
// NEURON_RELU_EN defined: ReLU; undefined: identity.
module neuron_sat_act #(
  parameter int ACC_W = 7,
  parameter int OUT_W = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res
);

  // One guard bit so the bounds fit even when ACC_W <= OUT_W.
  localparam int W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [W-1:0] MAXV =
    W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] MINV =
    W'(-(1 << (OUT_W - 1)));

  logic signed [W-1:0]     ext;
  logic signed [OUT_W-1:0] sat;

  always_comb begin
    ext = {{(W - ACC_W){acc[ACC_W-1]}}, acc};
    sat = ext[OUT_W-1:0];
    if (ext > MAXV) begin
      sat = MAXV[OUT_W-1:0];
    end else if (ext < MINV) begin
      sat = MINV[OUT_W-1:0];
    end
  end

`ifdef NEURON_RELU_EN
  assign res = sat[OUT_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif

endmodule

// File: rtl/neuron_accum_act.sv
// Sums N_TERMS signed terms, saturates, activates, emits one result.
// Optional build macro: NEURON_RELU_EN (see neuron_sat_act).
module neuron_accum_act
  import neuron_pkg::*;
#(
  parameter int IN_W    = NEURON_IN_W,
  parameter int N_TERMS = 4,
  parameter int OUT_W   = NEURON_OUT_W,
  localparam int CW     = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  neuron_accum_act_if.slave bus,
  output logic [CW-1:0]     term_cnt
);

  localparam int ACC_W = IN_W + $clog2(N_TERMS) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  neuron_acc_state_t       state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] act;
  logic                    fire;

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == OUTPUT);
  assign fire = bus.in_valid & bus.in_ready;

  assign sum = acc + {{(ACC_W - IN_W){bus.in_data[IN_W-1]}},
                      bus.in_data};

  neuron_sat_act #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_sat_act (
    .acc(sum),
    .res(act)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      term_cnt     <= '0;
      bus.out_data <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          // Only a real transfer touches acc, so X on idle data is harmless.
          if (fire) begin
            acc      <= sum;
            term_cnt <= term_cnt + 1'b1;
            if (term_cnt == LAST) begin
              state        <= OUTPUT;
              bus.out_data <= act;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state    <= ACCUM;
            acc      <= '0;
            term_cnt <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accum_act.sv
// Directed bench for neuron_accum_act at OUT_W=6 and OUT_W=4.
// Honours NEURON_RELU_EN when computing expected results.
module tb_neuron_accum_act;

  logic clk;
  logic rst;
  logic [2:0] cnt6;
  logic [2:0] cnt4;

  int n_checks;
  int n_fail;

  neuron_accum_act_if #(.IN_W(4), .OUT_W(6)) a ();
  neuron_accum_act_if #(.IN_W(4), .OUT_W(4)) b ();

  neuron_accum_act #(.IN_W(4), .N_TERMS(4), .OUT_W(6)) u_dut6 (
    .clk(clk), .rst(rst), .bus(a), .term_cnt(cnt6)
  );

  neuron_accum_act #(.IN_W(4), .N_TERMS(4), .OUT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b), .term_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int t0, t1, t2, t3;
    int exp6;
    int exp4;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int act_fn(input int v);
`ifdef NEURON_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic drive(input logic v, input int d, input logic ordy);
    a.in_valid  = v;
    b.in_valid  = v;
    a.in_data   = 4'(d);
    b.in_data   = 4'(d);
    a.out_ready = ordy;
    b.out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic ordy);
    drive(1'b1, d, ordy);
    cyc();
  endtask

  task automatic chk_result(input string tag, input int e6, input int e4);
    chk({tag, " out_valid6"}, int'(a.out_valid), 1);
    chk({tag, " out_valid4"}, int'(b.out_valid), 1);
    chk({tag, " out_data6"}, int'(a.out_data), act_fn(e6));
    chk({tag, " out_data4"}, int'(b.out_data), act_fn(e4));
    chk({tag, " in_ready"}, int'(a.in_ready), 0);
    chk({tag, " term_cnt"}, int'(cnt6), 4);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle out_valid"}, int'(a.out_valid), 0);
    chk({tag, " idle in_ready"}, int'(a.in_ready), 1);
    chk({tag, " idle term_cnt"}, int'(cnt6), 0);
    chk({tag, " idle term_cnt4"}, int'(cnt4), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{3, 1, -2, 2, 4, 4};
    vecs[1] = '{7, 7, 7, 7, 28, 7};
    vecs[2] = '{-8, -8, -8, -8, -32, -8};
    vecs[3] = '{-1, -1, -1, -1, -4, -4};
    vecs[4] = '{7, 7, -8, 1, 7, 7};
    vecs[5] = '{-8, -8, -8, 7, -17, -8};

    rst = 1'b1;
    drive(1'b0, 0, 1'b1);
    repeat (3) cyc();
    chk("reset out_valid", int'(a.out_valid), 0);
    chk("reset in_ready", int'(a.in_ready), 1);
    chk("reset term_cnt", int'(cnt6), 0);
    chk("reset out_data", int'(a.out_data), 0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].t0, 1'b1);
      chk($sformatf("v%0d cnt1", i), int'(cnt6), 1);
      push(vecs[i].t1, 1'b1);
      push(vecs[i].t2, 1'b1);
      chk($sformatf("v%0d cnt3", i), int'(cnt6), 3);
      push(vecs[i].t3, 1'b1);
      drive(1'b0, 0, 1'b1);
      chk_result($sformatf("v%0d", i), vecs[i].exp6, vecs[i].exp4);
      cyc();
      chk_idle($sformatf("v%0d", i));
    end

    // Stalled output: no terms absorbed, result held.
    push(1, 1'b0);
    push(1, 1'b0);
    push(1, 1'b0);
    push(1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5, 1'b0);
      chk_result($sformatf("stall%0d", k), 4, 4);
      cyc();
    end
    chk_result("stall end", 4, 4);
    drive(1'b0, 0, 1'b1);
    cyc();
    chk_idle("release");
    push(1, 1'b1);
    push(2, 1'b1);
    push(3, 1'b1);
    push(-1, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk_result("after stall", 5, 5);
    cyc();

    // Bubble mid-group holds acc and term_cnt.
    push(2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 1'b1);
      a.in_data = 'x;
      b.in_data = 'x;
      cyc();
      chk($sformatf("bubble cnt%0d", k), int'(cnt6), 1);
    end
    push(2, 1'b1);
    push(2, 1'b1);
    push(2, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk_result("bubble", 8, 7);
    cyc();

    // Async reset mid-group.
    push(1, 1'b1);
    push(1, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk("pre-rst cnt", int'(cnt6), 2);
    #2 rst = 1'b1;
    #1;
    chk("rst mid cnt", int'(cnt6), 0);
    chk("rst mid out_valid", int'(a.out_valid), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Async reset during OUTPUT.
    push(3, 1'b0);
    push(3, 1'b0);
    push(3, 1'b0);
    push(3, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk_result("pre-rst out", 12, 7);
    #2 rst = 1'b1;
    #1;
    chk("rst out out_valid", int'(a.out_valid), 0);
    chk("rst out in_ready", int'(a.in_ready), 1);
    chk("rst out term_cnt", int'(cnt6), 0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 0, 1'b1);
    cyc();
    chk_idle("post rst");
    push(1, 1'b1);
    push(1, 1'b1);
    push(1, 1'b1);
    push(1, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk_result("post rst", 4, 4);
    cyc();
    chk_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
